// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer that shares one single-port,
// word-addressed 32-bit memory between an instruction-fetch port (I, read-only)
// and a load/store port (D, read/write). Each granted access occupies exactly
// one memory cycle; its response is registered on the following edge. Byte
// addresses become word addresses here. Misaligned or out-of-range addresses
// fault: they never write, they return zero data, and they raise err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; arbitrate on the next edge
// SERVE_I | memory cycle owned by the fetch port (i_gnt high)
// SERVE_D | memory cycle owned by the load/store port (d_gnt high)

module mem_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_d;      // 1 when the most recent grant went to D
  logic [31:0] a_q;
  logic        we_q;
  logic [31:0] wd_q;
  logic        fault;

  // The address latched at the grant edge is checked once and the result is
  // shared by the write gate and by both response paths.
  assign fault = (a_q[1:0] != 2'b00) || (a_q[31:ADDR_W+2] != '0);

  // Memory drive comes straight from the latched request. The write enable is
  // also gated by rst_n so that a reset cycle can never write.
  assign mem_addr  = a_q[ADDR_W+1:2];
  assign mem_wdata = wd_q;
  assign mem_we    = (state == SERVE_D) && we_q && !fault && rst_n;

  // Arbitration. A serve cycle hands the memory straight to the other port if
  // that port is waiting, which lets both ports alternate with no gap. The
  // port being served is ignored at the end of its own cycle.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = last_d ? SERVE_I : SERVE_D;
        else if (i_req)     state_nxt = SERVE_I;
        else if (d_req)     state_nxt = SERVE_D;
        else                state_nxt = IDLE;
      end
      SERVE_I: state_nxt = d_req ? SERVE_D : IDLE;
      SERVE_D: state_nxt = i_req ? SERVE_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer: state, request latch, and the registered grant and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      a_q      <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      i_gnt    <= (state_nxt == SERVE_I);
      d_gnt    <= (state_nxt == SERVE_D);
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;

      if (state == SERVE_I) begin
        i_rvalid <= 1'b1;
        i_err    <= fault;
        i_rdata  <= fault ? 32'd0 : mem_rdata;
      end

      if (state == SERVE_D) begin
        d_rvalid <= 1'b1;
        d_err    <= fault;
        d_rdata  <= (fault || we_q) ? 32'd0 : mem_rdata;
      end

      if (state_nxt == SERVE_I) begin
        a_q    <= i_addr;
        we_q   <= 1'b0;
        wd_q   <= '0;
        last_d <= 1'b0;
      end else if (state_nxt == SERVE_D) begin
        a_q    <= d_addr;
        we_q   <= d_we;
        wd_q   <= d_wdata;
        last_d <= 1'b1;
      end
    end
  end

endmodule
